// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round sequencer: owns the round state, round counter and key latch,
// steers the external state mux and publishes the ciphertext with a one-cycle done pulse.
module aes_round_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    input  logic [127:0] mux_out,
    input  logic [127:0] round_out,
    output logic         sel,
    output logic [127:0] state,
    output logic [127:0] cipher_key,
    output logic [3:0]   round_num,
    output logic         last_round,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [3:0] LAST_RND = 4'd10;

    logic [0:0]   fsm_q,   fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q,   key_d;
    logic [3:0]   round_q, round_d;
    logic         done_q,  done_d;
    logic [127:0] ct_q,    ct_d;

    // Next-state logic for the sequencer FSM and its datapath registers.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        ct_d    = ct_q;
        case (fsm_q)
            ST_IDLE: begin
                round_d = 4'd0;
                if (start) begin
                    // mux_out carries plaintext here since sel is low in IDLE
                    state_d = mux_out ^ key;
                    key_d   = key;
                    round_d = 4'd1;
                    fsm_d   = ST_RUN;
                end else begin
                    fsm_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                state_d = round_out;
                if (round_q == LAST_RND) begin
                    ct_d    = round_out;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    fsm_d   = ST_IDLE;
                end else if (round_q < LAST_RND) begin
                    round_d = round_q + 4'd1;
                end else begin
                    // counter corrupted to 11..15: abandon the block without a result
                    round_d = 4'd0;
                    fsm_d   = ST_IDLE;
                end
            end
            default: begin
                round_d = 4'd0;
                fsm_d   = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= 128'd0;
            key_q   <= 128'd0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
            ct_q    <= 128'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
            ct_q    <= ct_d;
        end
    end

    assign sel        = (fsm_q == ST_RUN);
    assign busy       = (fsm_q == ST_RUN);
    assign last_round = (round_q == LAST_RND);
    assign state      = state_q;
    assign cipher_key = key_q;
    assign round_num  = round_q;
    assign done       = done_q;
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: models the state mux and AES round datapath around the DUT
// and compares timing and results against a full AES-128 reference.
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] plaintext, key, mux_out, round_out;
    logic         sel, last_round, busy, done;
    logic [127:0] state, cipher_key, ciphertext;
    logic [3:0]   round_num;

    int n_checks   = 0;
    int n_pass     = 0;
    int done_seen  = 0;

    localparam logic [127:0] PT1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] LOAD1 = 128'h00102030405060708090a0b0c0d0e0f0;

    always #5 clk = ~clk;

    // GF(2^8) multiply with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from first principles: inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, sq, b;
        r = 8'h01; sq = x;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rot, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h000000};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input logic [3:0] r);
        logic [127:0] kk;
        logic [7:0]   rc;
        kk = k; rc = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            if (i <= int'(r)) begin
                kk = key_next(kk, rc);
                rc = gmul(rc, 8'h02);
            end
        end
        return kk;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (!last) begin
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ rk;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s, kk;
        logic [7:0]   rc;
        s = pt ^ k; kk = k; rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            kk = key_next(kk, rc);
            rc = gmul(rc, 8'h02);
            s  = aes_round(s, kk, r == 10);
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    assign mux_out   = sel ? state : plaintext;
    assign round_out = aes_round(state, round_key(cipher_key, round_num), last_round);

    always @(negedge clk) if (done === 1'b1) done_seen++;

    aes_round_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext), .key(key),
        .mux_out(mux_out), .round_out(round_out), .sel(sel), .state(state),
        .cipher_key(cipher_key), .round_num(round_num), .last_round(last_round),
        .busy(busy), .done(done), .ciphertext(ciphertext)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 128'({sel, busy, done, last_round, round_num}), 128'd0);
        chk({tag, "_state"}, state, 128'd0);
        chk({tag, "_ckey"}, cipher_key, 128'd0);
        chk({tag, "_ct"}, ciphertext, 128'd0);
    endtask

    task automatic wait_done(input int limit, inout int lat);
        while (lat < limit && done !== 1'b1) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] k,
                             output logic [127:0] ct, output int lat);
        plaintext = pt; key = k; start = 1'b1;
        tick();
        start = 1'b0; plaintext = rand128(); key = rand128();
        lat = 0;
        wait_done(20, lat);
        ct = ciphertext;
    endtask

    initial begin
        logic [127:0] s_exp, k_exp, ct, pt, kk;
        logic [7:0]   rc;
        int           base, lat;

        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        logic [127:0] s_exp, k_exp, ct, pt, kk;
        logic [7:0]   rc;
        int           base, lat;

        rst_n = 1'b0; start = 1'b0; plaintext = 128'd0; key = 128'd0;
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk_all_zero("idle_after_reset");

        // Load, C.1 vector, ignored starts and key change mid-run
        plaintext = PT1; key = KEY1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_state", state, LOAD1);
        chk("load_round", 128'(round_num), 128'd1);
        chk("load_sel_busy", 128'({sel, busy}), 128'd3);
        s_exp = LOAD1; k_exp = KEY1; rc = 8'h01; base = done_seen;
        for (int k = 1; k <= 10; k++) begin
            chk("last_round", 128'(last_round), 128'(k == 10));
            if (k == 3 || k == 7) begin
                start = 1'b1; plaintext = rand128();
            end else begin
                start = 1'b0;
            end
            if (k == 5) key = {128{1'b1}};
            tick();
            k_exp = key_next(k_exp, rc); rc = gmul(rc, 8'h02);
            s_exp = aes_round(s_exp, k_exp, k == 10);
            chk("round_state", state, s_exp);
            if (k < 10) begin
                chk("round_num", 128'(round_num), 128'(k + 1));
                chk("no_early_done", 128'(done), 128'd0);
            end else begin
                chk("done_at_10", 128'(done), 128'd1);
                chk("ct_c1", ciphertext, CT1);
                chk("idle_round", 128'(round_num), 128'd0);
                chk("idle_busy", 128'(busy), 128'd0);
            end
        end
        start = 1'b0;
        chk("ckey_stable", cipher_key, KEY1);
        tick();
        chk("done_one_cycle", 128'(done), 128'd0);
        chk("single_done", 128'(done_seen - base), 128'd1);
        chk("ct_held", ciphertext, CT1);

        // Reset in the middle of a run
        plaintext = rand128(); key = rand128(); start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_round5", 128'(round_num), 128'd5);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        base = done_seen;
        tick(); tick();
        chk("reset_no_done", 128'(done_seen - base), 128'd0);
        chk("reset_ct_zero", ciphertext, 128'd0);
        rst_n = 1'b1;
        tick();
        pt = rand128(); kk = rand128();
        run_block(pt, kk, ct, lat);
        chk("post_reset_latency", 128'(lat), 128'd10);
        chk("post_reset_ct", ct, aes_encrypt(pt, kk));
        tick();

        // Back-to-back with start held
        plaintext = PT1; key = KEY1; start = 1'b1;
        tick();
        plaintext = 128'd0;
        lat = 0;
        wait_done(20, lat);
        chk("b2b_first_latency", 128'(lat), 128'd10);
        chk("b2b_first_ct", ciphertext, CT1);
        chk("b2b_done_idle", 128'(busy), 128'd0);
        tick();
        start = 1'b0;
        chk("b2b_reload_state", state, KEY1);
        chk("b2b_reload_round", 128'(round_num), 128'd1);
        lat = 1;
        wait_done(25, lat);
        chk("b2b_spacing", 128'(lat), 128'd11);
        chk("b2b_second_ct", ciphertext, aes_encrypt(128'd0, KEY1));
        tick();

        // Random blocks against the reference
        for (int i = 0; i < 4; i++) begin
            pt = rand128(); kk = rand128();
            run_block(pt, kk, ct, lat);
            chk("rand_latency", 128'(lat), 128'd10);
            chk("rand_ct", ct, aes_encrypt(pt, kk));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
